// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: day/hour/minute/second clock with NA alarm channels.
// Each channel rings for RING_S pulses, auto-stops, and can be cancelled.
// Optional snooze is compiled in with `define SNOOZE_EN.
// Ports:
//   Pulse/Reset          : 1 Hz clock, async active-low reset
//   Timeset/Alarmset     : set modes (Timeset wins)
//   AlarmSel             : channel being set/displayed
//   Minadv/Hrsadv/Dayadv : advance buttons
//   Alarmon              : per-channel enable
//   Snooze               : snooze request (SNOOZE_EN builds only)
//   TSec/TMin/THrs/TDay  : current time, binary
//   DispMin/DispHrs      : time, or selected alarm while Alarmset
//   BuzzCh/Buzz          : per-channel ringing and their OR
`timescale 1ns/1ps
module multi_alarm_clock #(
    parameter int NS     = 60,
    parameter int NH     = 24,
    parameter int ND     = 7,
    parameter int NA     = 2,
    parameter int RING_S = 60,
    parameter int SNZ_M  = 5,
    localparam int AW    = (NA > 1) ? $clog2(NA) : 1
) (
    input  logic          Pulse,
    input  logic          Reset,
    input  logic          Timeset,
    input  logic          Alarmset,
    input  logic [AW-1:0] AlarmSel,
    input  logic          Minadv,
    input  logic          Hrsadv,
    input  logic          Dayadv,
    input  logic [NA-1:0] Alarmon,
    input  logic          Snooze,
    output logic [6:0]    TSec,
    output logic [6:0]    TMin,
    output logic [6:0]    THrs,
    output logic [2:0]    TDay,
    output logic [6:0]    DispMin,
    output logic [6:0]    DispHrs,
    output logic [NA-1:0] BuzzCh,
    output logic          Buzz
);

    localparam int RW = $clog2(RING_S + 1);
`ifdef SNOOZE_EN
    localparam int SNZ_N = SNZ_M * NS;
    localparam int ZW    = $clog2(SNZ_N + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef SNOOZE_EN
        ST_SNZ  = 2'd2,
`endif
        ST_RING = 2'd1
    } state_t;

    function automatic logic [6:0] inc_mod(input logic [6:0] v, input int m);
        return (int'(v) == m - 1) ? 7'd0 : v + 7'd1;
    endfunction

    logic          run;
    logic          sec_wrap;
    logic          min_wrap;
    logic          hrs_wrap;
    logic [6:0]    tsec_q, tsec_d;
    logic [6:0]    tmin_q, tmin_d;
    logic [6:0]    thrs_q, thrs_d;
    logic [2:0]    tday_q, tday_d;
    logic [6:0]    amin_q [NA];
    logic [6:0]    amin_d [NA];
    logic [6:0]    ahrs_q [NA];
    logic [6:0]    ahrs_d [NA];
    state_t        st_q   [NA];
    state_t        st_d   [NA];
    logic [RW-1:0] ring_q [NA];
    logic [RW-1:0] ring_d [NA];
`ifdef SNOOZE_EN
    logic [ZW-1:0] snz_q  [NA];
    logic [ZW-1:0] snz_d  [NA];
`else
    logic          unused_snz;
    assign unused_snz = ^{Snooze, 32'(SNZ_M)};
`endif
    logic [NA-1:0] match;
    logic [NA-1:0] buzz_ch_q, buzz_ch_d;
    logic [6:0]    disp_min, disp_hrs;

    // Time counters: run mode carries, set mode advances each field alone.
    always_comb begin
        run      = !Timeset;
        sec_wrap = (tsec_q == 7'(NS - 1));
        min_wrap = (tmin_q == 7'(NS - 1));
        hrs_wrap = (thrs_q == 7'(NH - 1));
        tsec_d   = tsec_q;
        tmin_d   = tmin_q;
        thrs_d   = thrs_q;
        tday_d   = tday_q;
        if (run) begin
            tsec_d = inc_mod(tsec_q, NS);
            if (sec_wrap) begin
                tmin_d = inc_mod(tmin_q, NS);
                if (min_wrap) begin
                    thrs_d = inc_mod(thrs_q, NH);
                    if (hrs_wrap) begin
                        tday_d = (tday_q == 3'(ND - 1)) ? 3'd0 : tday_q + 3'd1;
                    end
                end
            end
        end else begin
            if (Minadv) tmin_d = inc_mod(tmin_q, NS);
            if (Hrsadv) thrs_d = inc_mod(thrs_q, NH);
            if (Dayadv) begin
                tday_d = (tday_q == 3'(ND - 1)) ? 3'd0 : tday_q + 3'd1;
            end
        end
    end

    // Alarm registers; an out-of-range AlarmSel matches no channel.
    always_comb begin
        for (int i = 0; i < NA; i++) begin
            amin_d[i] = amin_q[i];
            ahrs_d[i] = ahrs_q[i];
            if (Alarmset && run && int'(AlarmSel) == i) begin
                if (Minadv) amin_d[i] = inc_mod(amin_q[i], NS);
                if (Hrsadv) ahrs_d[i] = inc_mod(ahrs_q[i], NH);
            end
        end
    end

    always_comb begin
        disp_min = tmin_q;
        disp_hrs = thrs_q;
        if (Alarmset) begin
            disp_min = '0;
            disp_hrs = '0;
            for (int i = 0; i < NA; i++) begin
                if (int'(AlarmSel) == i) begin
                    disp_min = amin_q[i];
                    disp_hrs = ahrs_q[i];
                end
            end
        end
    end

    // Per-channel ring FSM. Counters count down the cycles left in a state;
    // a value of 1 means this is the last cycle.
    always_comb begin
        for (int i = 0; i < NA; i++) begin
            match[i] = Alarmon[i] && run && (tsec_q == 7'd0)
                && (tmin_q == amin_q[i]) && (thrs_q == ahrs_q[i]);
            st_d[i]   = st_q[i];
            ring_d[i] = ring_q[i];
`ifdef SNOOZE_EN
            snz_d[i]  = snz_q[i];
`endif
            case (st_q[i])
                ST_IDLE: begin
                    if (match[i]) begin
                        st_d[i]   = ST_RING;
                        ring_d[i] = RW'(RING_S);
                    end
                end
                ST_RING: begin
                    if (!Alarmon[i]) begin
                        st_d[i] = ST_IDLE;
`ifdef SNOOZE_EN
                    end else if (Snooze) begin
                        st_d[i]  = ST_SNZ;
                        snz_d[i] = ZW'(SNZ_N);
`endif
                    end else if (ring_q[i] == RW'(1)) begin
                        st_d[i] = ST_IDLE;
                    end else begin
                        ring_d[i] = ring_q[i] - RW'(1);
                    end
                end
`ifdef SNOOZE_EN
                ST_SNZ: begin
                    if (!Alarmon[i]) begin
                        st_d[i] = ST_IDLE;
                    end else if (snz_q[i] == ZW'(1)) begin
                        st_d[i]   = ST_RING;
                        ring_d[i] = RW'(RING_S);
                    end else begin
                        snz_d[i] = snz_q[i] - ZW'(1);
                    end
                end
`endif
                default: st_d[i] = ST_IDLE;
            endcase
            buzz_ch_d[i] = (st_d[i] == ST_RING);
        end
    end

    always_ff @(posedge Pulse or negedge Reset) begin
        if (!Reset) begin
            tsec_q    <= '0;
            tmin_q    <= '0;
            thrs_q    <= '0;
            tday_q    <= '0;
            buzz_ch_q <= '0;
            for (int i = 0; i < NA; i++) begin
                amin_q[i] <= '0;
                ahrs_q[i] <= '0;
                st_q[i]   <= ST_IDLE;
                ring_q[i] <= '0;
`ifdef SNOOZE_EN
                snz_q[i]  <= '0;
`endif
            end
        end else begin
            tsec_q    <= tsec_d;
            tmin_q    <= tmin_d;
            thrs_q    <= thrs_d;
            tday_q    <= tday_d;
            buzz_ch_q <= buzz_ch_d;
            for (int i = 0; i < NA; i++) begin
                amin_q[i] <= amin_d[i];
                ahrs_q[i] <= ahrs_d[i];
                st_q[i]   <= st_d[i];
                ring_q[i] <= ring_d[i];
`ifdef SNOOZE_EN
                snz_q[i]  <= snz_d[i];
`endif
            end
        end
    end

    assign TSec    = tsec_q;
    assign TMin    = tmin_q;
    assign THrs    = thrs_q;
    assign TDay    = tday_q;
    assign DispMin = disp_min;
    assign DispHrs = disp_hrs;
    assign BuzzCh  = buzz_ch_q;
    assign Buzz    = |buzz_ch_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Bench for multi_alarm_clock: vector table, directed corner sequences,
// and randomized runs against a seconds-of-week reference model.
`timescale 1ns/1ps
module tb_multi_alarm_clock;

    localparam int NS     = 60;
    localparam int NH     = 24;
    localparam int ND     = 7;
    localparam int NA     = 2;
    localparam int RING_S = 60;
    localparam int SNZ_M  = 5;
    localparam int AW     = (NA > 1) ? $clog2(NA) : 1;
    localparam int DAYS   = NH * NS * NS;
    localparam int WEEK   = ND * DAYS;

    logic          Pulse = 1'b0;
    logic          Reset = 1'b0;
    logic          Timeset = 1'b0;
    logic          Alarmset = 1'b0;
    logic [AW-1:0] AlarmSel = '0;
    logic          Minadv = 1'b0;
    logic          Hrsadv = 1'b0;
    logic          Dayadv = 1'b0;
    logic [NA-1:0] Alarmon = '0;
    logic          Snooze = 1'b0;
    logic [6:0]    TSec, TMin, THrs, DispMin, DispHrs;
    logic [2:0]    TDay;
    logic [NA-1:0] BuzzCh;
    logic          Buzz;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time as seconds into the week, alarms as numbers,
    // ringing as "cycles of ringing / snoozing left" per channel.
    int m_now;
    int m_am   [NA];
    int m_ah   [NA];
    int m_ring [NA];
    int m_snz  [NA];

    multi_alarm_clock #(
        .NS(NS), .NH(NH), .ND(ND), .NA(NA), .RING_S(RING_S), .SNZ_M(SNZ_M)
    ) dut (
        .Pulse(Pulse), .Reset(Reset), .Timeset(Timeset),
        .Alarmset(Alarmset), .AlarmSel(AlarmSel), .Minadv(Minadv),
        .Hrsadv(Hrsadv), .Dayadv(Dayadv), .Alarmon(Alarmon),
        .Snooze(Snooze), .TSec(TSec), .TMin(TMin), .THrs(THrs),
        .TDay(TDay), .DispMin(DispMin), .DispHrs(DispHrs),
        .BuzzCh(BuzzCh), .Buzz(Buzz)
    );

    always #5 Pulse = ~Pulse;

    function automatic int f_sec();
        return m_now % NS;
    endfunction
    function automatic int f_min();
        return (m_now / NS) % NS;
    endfunction
    function automatic int f_hrs();
        return (m_now / (NS * NS)) % NH;
    endfunction
    function automatic int f_day();
        return m_now / DAYS;
    endfunction

    task automatic model_reset();
        m_now = 0;
        for (int i = 0; i < NA; i++) begin
            m_am[i] = 0;
            m_ah[i] = 0;
            m_ring[i] = 0;
            m_snz[i] = 0;
        end
    endtask

    task automatic model_edge();
        int s, mi, h, d;
        logic [NA-1:0] mt;
        s = f_sec();
        mi = f_min();
        h = f_hrs();
        d = f_day();
        for (int i = 0; i < NA; i++)
            mt[i] = Alarmon[i] && !Timeset && s == 0 && mi == m_am[i] && h == m_ah[i];
        if (!Timeset) begin
            m_now = (m_now + 1) % WEEK;
        end else begin
            if (Minadv) mi = (mi + 1) % NS;
            if (Hrsadv) h = (h + 1) % NH;
            if (Dayadv) d = (d + 1) % ND;
            m_now = ((d * NH + h) * NS + mi) * NS + s;
        end
        if (Alarmset && !Timeset && int'(AlarmSel) < NA) begin
            if (Minadv) m_am[AlarmSel] = (m_am[AlarmSel] + 1) % NS;
            if (Hrsadv) m_ah[AlarmSel] = (m_ah[AlarmSel] + 1) % NH;
        end
        for (int i = 0; i < NA; i++) begin
            if (m_ring[i] > 0) begin
                if (!Alarmon[i]) m_ring[i] = 0;
`ifdef SNOOZE_EN
                else if (Snooze) begin
                    m_ring[i] = 0;
                    m_snz[i] = SNZ_M * NS;
                end
`endif
                else m_ring[i]--;
            end else if (m_snz[i] > 0) begin
                if (!Alarmon[i]) m_snz[i] = 0;
                else begin
                    m_snz[i]--;
                    if (m_snz[i] == 0) m_ring[i] = RING_S;
                end
            end else if (mt[i]) begin
                m_ring[i] = RING_S;
            end
        end
    endtask

    task automatic check_all();
        int edm, edh;
        logic [NA-1:0] eb;
        edm = f_min();
        edh = f_hrs();
        if (Alarmset) begin
            edm = 0;
            edh = 0;
            if (int'(AlarmSel) < NA) begin
                edm = m_am[AlarmSel];
                edh = m_ah[AlarmSel];
            end
        end
        for (int i = 0; i < NA; i++) eb[i] = (m_ring[i] > 0);
        n_checks++;
        if (TSec !== 7'(f_sec()) || TMin !== 7'(f_min()) || THrs !== 7'(f_hrs())
            || TDay !== 3'(f_day()) || DispMin !== 7'(edm) || DispHrs !== 7'(edh)
            || BuzzCh !== eb || Buzz !== (|eb)) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL model @%0t: got %0d:%0d:%0d d%0d disp %0d:%0d buzz %b/%b, want %0d:%0d:%0d d%0d disp %0d:%0d buzz %b/%b",
                    $time, THrs, TMin, TSec, TDay, DispHrs, DispMin, BuzzCh, Buzz,
                    f_hrs(), f_min(), f_sec(), f_day(), edh, edm, eb, |eb);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Pulse);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        Timeset = 1'b0;
        Alarmset = 1'b0;
        AlarmSel = '0;
        Minadv = 1'b0;
        Hrsadv = 1'b0;
        Dayadv = 1'b0;
        Alarmon = '0;
        Snooze = 1'b0;
    endtask

    // Called 1 unit after an edge; checks the asynchronous clear well
    // before the next edge.
    task automatic do_reset();
        clear_inputs();
        #2 Reset = 1'b0;
        #1;
        chk("rst_time", int'({THrs, TMin, TSec, TDay}), 0);
        chk("rst_disp", int'({DispHrs, DispMin}), 0);
        chk("rst_buzz", int'({BuzzCh, Buzz}), 0);
        model_reset();
        Reset = 1'b1;
    endtask

    task automatic goto_time(input int h, input int m, input int s, input int d);
        clear_inputs();
        for (int k = 0; k < NS && f_sec() != s; k++) step();
        Timeset = 1'b1;
        Minadv = 1'b1;
        for (int k = 0; k < NS && f_min() != m; k++) step();
        Minadv = 1'b0;
        Hrsadv = 1'b1;
        for (int k = 0; k < NH && f_hrs() != h; k++) step();
        Hrsadv = 1'b0;
        Dayadv = 1'b1;
        for (int k = 0; k < ND && f_day() != d; k++) step();
        Dayadv = 1'b0;
    endtask

    task automatic set_alarm(input int ch, input int h, input int m);
        clear_inputs();
        Alarmset = 1'b1;
        AlarmSel = AW'(ch);
        Hrsadv = 1'b1;
        for (int k = 0; k < NH && m_ah[ch] != h; k++) step();
        Hrsadv = 1'b0;
        Minadv = 1'b1;
        for (int k = 0; k < NS && m_am[ch] != m; k++) step();
        Minadv = 1'b0;
        Alarmset = 1'b0;
    endtask

    typedef struct {
        logic ts, as, ma, ha, da;
        int   sel;
        int   es, em, eh, ed, edm, edh;
    } vec_t;

    function automatic vec_t mk(input logic ts, input logic as, input int sel,
                                input logic ma, input logic ha, input logic da,
                                input int es, input int em, input int eh,
                                input int ed, input int edm, input int edh);
        vec_t v;
        v.ts = ts; v.as = as; v.sel = sel;
        v.ma = ma; v.ha = ha; v.da = da;
        v.es = es; v.em = em; v.eh = eh; v.ed = ed;
        v.edm = edm; v.edh = edh;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [9];
        int ch, off, tgt;

        // Vectors start from the reset state 00:00:00 day 0.
        tbl[0] = mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[1] = mk(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 1);
        tbl[2] = mk(1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1);
        tbl[3] = mk(1, 1, 0, 1, 1, 1, 0, 2, 2, 2, 0, 0);
        tbl[4] = mk(0, 1, 0, 1, 0, 0, 1, 2, 2, 2, 1, 0);
        tbl[5] = mk(0, 1, 1, 1, 1, 0, 2, 2, 2, 2, 1, 1);
        tbl[6] = mk(0, 1, 0, 0, 0, 0, 3, 2, 2, 2, 1, 0);
        tbl[7] = mk(0, 0, 0, 0, 0, 0, 4, 2, 2, 2, 2, 2);
        tbl[8] = mk(0, 0, 0, 1, 0, 1, 5, 2, 2, 2, 2, 2);

        model_reset();
        @(posedge Pulse);
        #1;
        do_reset();

        for (int v = 0; v < 9; v++) begin
            Timeset = tbl[v].ts;
            Alarmset = tbl[v].as;
            AlarmSel = AW'(tbl[v].sel);
            Minadv = tbl[v].ma;
            Hrsadv = tbl[v].ha;
            Dayadv = tbl[v].da;
            step();
            chk($sformatf("vec%0d_time", v), int'({THrs, TMin, TSec, TDay}),
                (tbl[v].eh << 17) | (tbl[v].em << 10) | (tbl[v].es << 3) | tbl[v].ed);
            chk($sformatf("vec%0d_disp", v), int'({DispHrs, DispMin}),
                (tbl[v].edh << 7) | tbl[v].edm);
        end

        // Full carry chain including day wrap.
        goto_time(23, 59, 58, 6);
        Timeset = 1'b0;
        step();
        chk("carry_235959", int'({THrs, TMin, TSec, TDay}),
            (23 << 17) | (59 << 10) | (59 << 3) | 6);
        step();
        chk("carry_wrap", int'({THrs, TMin, TSec, TDay}), 0);

        // Set-mode minute wrap does not carry and seconds hold.
        goto_time(10, 59, 20, 2);
        Minadv = 1'b1;
        step();
        Minadv = 1'b0;
        chk("setmin_wrap", int'({THrs, TMin, TSec}), (10 << 14) | 20);

        // Asynchronous reset at 13:45:30 day 3.
        goto_time(13, 45, 30, 3);
        chk("pre_reset", int'({THrs, TMin, TSec, TDay}),
            (13 << 17) | (45 << 10) | (30 << 3) | 3);
        do_reset();

        // Single alarm, ring length.
        set_alarm(0, 7, 30);
        goto_time(7, 29, 50, 0);
        Timeset = 1'b0;
        Alarmon = NA'(1);
        repeat (10) step();
        chk("ring_0730_00", int'(BuzzCh), 0);
        step();
        chk("ring_0730_01", int'(BuzzCh), 1);
        repeat (59) step();
        chk("ring_0731_00", int'(BuzzCh), 1);
        step();
        chk("ring_0731_01", int'({BuzzCh, Buzz}), 0);

        // Two channels at the same time, one cancelled.
        set_alarm(0, 6, 0);
        set_alarm(1, 6, 0);
        goto_time(5, 59, 55, 0);
        Timeset = 1'b0;
        Alarmon = NA'(3);
        repeat (5) step();
        step();
        chk("dual_0600_01", int'(BuzzCh), 3);
        repeat (9) step();
        Alarmon = NA'(2);
        step();
        chk("dual_cancel", int'(BuzzCh), 2);
        chk("dual_buzz", int'(Buzz), 1);

        // Snooze at 07:30:05.
        set_alarm(0, 7, 30);
        set_alarm(1, 0, 0);
        goto_time(7, 29, 58, 0);
        Timeset = 1'b0;
        Alarmon = NA'(1);
        repeat (7) step();
        chk("snz_ringing", int'(Buzz), 1);
        Snooze = 1'b1;
        step();
        Snooze = 1'b0;
`ifdef SNOOZE_EN
        chk("snz_start", int'(Buzz), 0);
        repeat (299) step();
        chk("snz_073505", int'(Buzz), 0);
        step();
        chk("snz_073506", int'(Buzz), 1);
        repeat (59) step();
        chk("snz_ring_end", int'(Buzz), 1);
        step();
        chk("snz_stop", int'(Buzz), 0);
`else
        chk("snz_ignored", int'(Buzz), 1);
`endif

        // Randomized runs starting a few seconds before a chosen alarm.
        for (int t = 0; t < 12; t++) begin
            for (int c = 0; c < NA; c++)
                set_alarm(c, $urandom_range(NH - 1, 0), $urandom_range(NS - 1, 0));
            ch = $urandom_range(NA - 1, 0);
            off = $urandom_range(12, 2);
            tgt = ((m_ah[ch] * NS + m_am[ch]) * NS - off + DAYS) % DAYS;
            goto_time(tgt / (NS * NS), (tgt / NS) % NS, tgt % NS,
                      $urandom_range(ND - 1, 0));
            Timeset = 1'b0;
            Alarmon = '1;
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(99, 0) < 3) Alarmon = NA'($urandom);
                Timeset = ($urandom_range(99, 0) < 3);
                Alarmset = ($urandom_range(99, 0) < 20);
                AlarmSel = AW'($urandom);
                Minadv = ($urandom_range(99, 0) < 10);
                Hrsadv = ($urandom_range(99, 0) < 10);
                Dayadv = ($urandom_range(99, 0) < 10);
                Snooze = ($urandom_range(99, 0) < 3);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
